// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: bus widths, load-type encodings, bus layouts.
// Optional feature macro: MEM_LWLR_EN (unaligned lwl/lwr merge).
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 78;
  localparam int MS_TO_WS_BUS_WD = 73;

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4,
    LD_LWL = 3'd5,
    LD_LWR = 3'd6
  } ld_type_e;

  // execute -> memory bus, MSB first
  typedef struct packed {
    logic        req_issued;
    logic        res_from_mem;
    ld_type_e    ld_type;
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  // memory -> write-back bus, MSB first
  typedef struct packed {
    logic [3:0]  gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ms_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load alignment / extension: picks the addressed byte or half of the
// returned word and extends it; reports which register bytes get written.
// With MEM_LWLR_EN, lwl/lwr shift the word into place and return partial
// byte strobes; otherwise they fall through to the lw path.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  ld_type_e    ld_type,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data,
  output logic [3:0]  strb
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // addressed byte and half-word of the returned word
  always_comb begin
    w_byte = rdata[7:0];
    case (addr)
      2'd0: w_byte = rdata[7:0];
      2'd1: w_byte = rdata[15:8];
      2'd2: w_byte = rdata[23:16];
      2'd3: w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // extension and per-type strobes
  always_comb begin
    data = rdata;
    strb = 4'hF;
    case (ld_type)
      LD_LB:  data = {{24{w_byte[7]}}, w_byte};
      LD_LBU: data = {24'd0, w_byte};
      LD_LH:  data = {{16{w_half[15]}}, w_half};
      LD_LHU: data = {16'd0, w_half};
`ifdef MEM_LWLR_EN
      // lwl fills the register from the top down, lwr from the bottom up
      LD_LWL: begin
        data = rdata << {~addr, 3'b000};
        strb = 4'hF << ~addr;
      end
      LD_LWR: begin
        data = rdata >> {addr, 3'b000};
        strb = 4'hF >> addr;
      end
`endif
      default: begin
        data = rdata;
        strb = 4'hF;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction, waits for its load response
// (buffering it if write-back stalls), aligns load data and drives the
// write-back bus plus forwarding info.
// Optional feature macro: MEM_LWLR_EN (lwl/lwr byte-merge loads).
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic                       ms_write_reg,
  output logic [4:0]                 ms_reg_dest,
  output logic                       ms_fwd_ok,
  output logic [31:0]                ms_fwd_data
);

  logic        r_ms_valid;
  es_bus_t     r_bus;
  logic        r_resp_buf_valid;
  logic [31:0] r_resp_buf;

  logic        w_need_resp;
  logic        w_ready_go;
  logic        w_leave;
  logic        w_capture;
  logic [31:0] w_ld_word;
  logic [31:0] w_ld_data;
  logic [3:0]  w_strb;
  logic [31:0] w_final;
  logic [3:0]  w_gr_we;
  ms_bus_t     w_out_bus;

  // a response only matters for an issued load that has not been answered yet
  assign w_need_resp = r_ms_valid && r_bus.req_issued && r_bus.res_from_mem;
  assign w_ready_go  = !w_need_resp || data_sram_data_ok || r_resp_buf_valid;
  assign ms_allowin  = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_leave     = ms_to_ws_valid && ws_allowin;
  // buffer only when the response can't be handed on this cycle
  assign w_capture   = w_need_resp && !r_resp_buf_valid && data_sram_data_ok && !ws_allowin;

  assign w_ld_word = r_resp_buf_valid ? r_resp_buf : data_sram_rdata;

  mem_load_align u_align (
    .ld_type (r_bus.ld_type),
    .addr    (r_bus.alu_result[1:0]),
    .rdata   (w_ld_word),
    .data    (w_ld_data),
    .strb    (w_strb)
  );

  assign w_final = r_bus.res_from_mem ? w_ld_data : r_bus.alu_result;
  assign w_gr_we = r_bus.res_from_mem ? (r_bus.gr_we & w_strb) : r_bus.gr_we;

  assign w_out_bus.gr_we        = w_gr_we;
  assign w_out_bus.dest         = r_bus.dest;
  assign w_out_bus.final_result = w_final;
  assign w_out_bus.pc           = r_bus.pc;
  assign ms_to_ws_bus           = w_out_bus;

  assign ms_write_reg = r_ms_valid && (w_gr_we != 4'd0);
  assign ms_reg_dest  = r_bus.dest;
  assign ms_fwd_ok    = ms_write_reg && w_ready_go;
  assign ms_fwd_data  = w_final;

  // stage occupancy and instruction bus register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ms_valid <= 1'b0;
      r_bus      <= '0;
    end else if (ms_allowin) begin
      r_ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) r_bus <= es_bus_t'(es_to_ms_bus);
    end
  end

  // response buffer: holds load data while write-back is stalled
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_resp_buf_valid <= 1'b0;
      r_resp_buf       <= 32'd0;
    end else if (w_leave) begin
      r_resp_buf_valid <= 1'b0;
    end else if (w_capture) begin
      r_resp_buf_valid <= 1'b1;
      r_resp_buf       <= data_sram_rdata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level model plus per-cycle compare,
// and directed scenarios with literal expectations.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ws_allowin;
  logic        ms_allowin;
  logic        es_to_ms_valid;
  logic [77:0] es_to_ms_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_to_ws_valid;
  logic [72:0] ms_to_ws_bus;
  logic        ms_write_reg;
  logic [4:0]  ms_reg_dest;
  logic        ms_fwd_ok;
  logic [31:0] ms_fwd_data;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_write_reg      (ms_write_reg),
    .ms_reg_dest       (ms_reg_dest),
    .ms_fwd_ok         (ms_fwd_ok),
    .ms_fwd_data       (ms_fwd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [77:0] mk(input bit req, input bit rfm, input logic [2:0] ld,
                                     input logic [3:0] we, input logic [4:0] dst,
                                     input logic [31:0] alu, input logic [31:0] pc);
    return {req, rfm, ld, we, dst, alu, pc};
  endfunction

  // reference load semantics expressed as shifts and masks on the word
  function automatic void mdl_load(input logic [2:0] ld, input logic [1:0] off,
                                   input logic [31:0] w, output logic [31:0] d,
                                   output logic [3:0] s);
    int sh;
    sh = 8 * int'(off);
    s  = 4'hF;
    d  = w;
    case (ld)
      3'd1: begin d = (w >> sh) & 32'hFF;   if (d[7])  d = d | 32'hFFFF_FF00; end
      3'd2: d = (w >> sh) & 32'hFF;
      3'd3: begin d = (w >> sh) & 32'hFFFF; if (d[15]) d = d | 32'hFFFF_0000; end
      3'd4: d = (w >> sh) & 32'hFFFF;
`ifdef MEM_LWLR_EN
      3'd5: begin d = w << (24 - sh); s = 4'(4'hF << (3 - int'(off))); end
      3'd6: begin d = w >> sh;        s = 4'(4'hF >> off); end
`endif
      default: d = w;
    endcase
  endfunction

  // model state: instruction held, and whether its response was parked
  logic        m_valid;
  logic [77:0] m_ins;
  logic        m_buf_v;
  logic [31:0] m_buf;

  // model update on each clock, from the stage's transfer rules
  always @(posedge clk or negedge resetn) begin : mdl
    logic need, rdy, ov, allow;
    if (!resetn) begin
      m_valid <= 1'b0;
      m_ins   <= '0;
      m_buf_v <= 1'b0;
      m_buf   <= '0;
    end else begin
      need  = m_valid && m_ins[77] && m_ins[76];
      rdy   = !need || m_buf_v || data_sram_data_ok;
      ov    = m_valid && rdy;
      allow = !m_valid || (rdy && ws_allowin);
      if (ov && ws_allowin) m_buf_v <= 1'b0;
      else if (need && !m_buf_v && data_sram_data_ok && !ws_allowin) begin
        m_buf_v <= 1'b1;
        m_buf   <= data_sram_rdata;
      end
      if (allow) begin
        m_valid <= es_to_ms_valid;
        if (es_to_ms_valid) m_ins <= es_to_ms_bus;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin : cmp
    logic need, rdy, ov;
    logic [31:0] word, res;
    logic [3:0]  s, gwe;
    if (!resetn) begin
      chk("rst_allowin", 32'(ms_allowin), 32'd1);
      chk("rst_out_valid", 32'(ms_to_ws_valid), 32'd0);
      chk("rst_write_reg", 32'(ms_write_reg), 32'd0);
      chk("rst_fwd_ok", 32'(ms_fwd_ok), 32'd0);
    end else begin
      need = m_valid && m_ins[77] && m_ins[76];
      rdy  = !need || m_buf_v || data_sram_data_ok;
      ov   = m_valid && rdy;
      chk("out_valid", 32'(ms_to_ws_valid), 32'(ov));
      chk("allowin", 32'(ms_allowin), 32'(!m_valid || (rdy && ws_allowin)));
      if (m_valid) begin
        word = m_buf_v ? m_buf : data_sram_rdata;
        if (m_ins[76]) begin
          mdl_load(m_ins[75:73], m_ins[33:32], word, res, s);
          gwe = m_ins[72:69] & s;
        end else begin
          res = m_ins[63:32];
          gwe = m_ins[72:69];
        end
        chk("write_reg", 32'(ms_write_reg), 32'(gwe != 4'd0));
        chk("reg_dest", 32'(ms_reg_dest), 32'(m_ins[68:64]));
        chk("fwd_ok", 32'(ms_fwd_ok), 32'((gwe != 4'd0) && rdy));
        if (ov) begin
          chk("bus_gr_we", 32'(ms_to_ws_bus[72:69]), 32'(gwe));
          chk("bus_dest", 32'(ms_to_ws_bus[68:64]), 32'(m_ins[68:64]));
          chk("bus_result", ms_to_ws_bus[63:32], res);
          chk("bus_pc", ms_to_ws_bus[31:0], m_ins[31:0]);
          chk("fwd_data", ms_fwd_data, res);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [77:0] b);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b;
    cyc();
    es_to_ms_valid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    ws_allowin = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata = '0;
    #1;
    chk("init_allowin", 32'(ms_allowin), 32'd1);
    chk("init_out_valid", 32'(ms_to_ws_valid), 32'd0);
    cyc(); cyc();
    resetn = 1'b1;
    cyc();

    // ALU op: passes after one cycle, forwardable
    issue(mk(1'b0, 1'b0, 3'd0, 4'hF, 5'd5, 32'h1234, 32'hBFC0_0000));
    chk("alu_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("alu_result", ms_to_ws_bus[63:32], 32'h0000_1234);
    chk("alu_fwd_ok", 32'(ms_fwd_ok), 32'd1);
    chk("alu_dest", 32'(ms_reg_dest), 32'd5);
    cyc();

    // lb at offset 3, response on the third cycle
    issue(mk(1'b1, 1'b1, 3'd1, 4'hF, 5'd6, 32'h1000_0003, 32'hBFC0_0004));
    chk("lb_wait1", 32'(ms_to_ws_valid), 32'd0);
    cyc();
    chk("lb_wait2", 32'(ms_to_ws_valid), 32'd0);
    cyc();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h80FF_FF00;
    #1;
    chk("lb_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("lb_result", ms_to_ws_bus[63:32], 32'hFFFF_FF80);
    cyc();
    data_sram_data_ok = 1'b0;

    // lhu at offset 2, response while write-back stalls -> buffered
    issue(mk(1'b1, 1'b1, 3'd4, 4'hF, 5'd7, 32'h1000_0002, 32'hBFC0_0008));
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    cyc();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_BEEF;
    chk("lhu_buf_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("lhu_buf_result", ms_to_ws_bus[63:32], 32'h0000_8001);
    cyc();
    ws_allowin = 1'b1;
    #1;
    chk("lhu_rel_result", ms_to_ws_bus[63:32], 32'h0000_8001);
    cyc();
    chk("lhu_gone", 32'(ms_to_ws_valid), 32'd0);
    // a fresh load must wait again, showing the buffer was released
    issue(mk(1'b1, 1'b1, 3'd0, 4'hF, 5'd8, 32'h1000_0010, 32'hBFC0_000C));
    chk("buf_cleared", 32'(ms_to_ws_valid), 32'd0);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0BAD_F00D;
    cyc();
    data_sram_data_ok = 1'b0;

    // back-to-back lw, one retire per data_ok
    issue(mk(1'b1, 1'b1, 3'd0, 4'hF, 5'd9, 32'h2000_0000, 32'hBFC0_0010));
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk(1'b1, 1'b1, 3'd0, 4'hF, 5'd10, 32'h2000_0004, 32'hBFC0_0014);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_1111;
    #1;
    chk("b2b_first", ms_to_ws_bus[63:32], 32'h1111_1111);
    chk("b2b_allowin", 32'(ms_allowin), 32'd1);
    cyc();
    es_to_ms_valid  = 1'b0;
    data_sram_rdata = 32'h2222_2222;
    #1;
    chk("b2b_second", ms_to_ws_bus[63:32], 32'h2222_2222);
    chk("b2b_second_pc", ms_to_ws_bus[31:0], 32'hBFC0_0014);
    cyc();
    data_sram_data_ok = 1'b0;
    chk("b2b_empty", 32'(ms_to_ws_valid), 32'd0);

    // reset while a load waits, then a stray data_ok
    issue(mk(1'b1, 1'b1, 3'd0, 4'hF, 5'd11, 32'h3000_0000, 32'hBFC0_0018));
    resetn = 1'b0;
    #1;
    chk("rstw_allowin", 32'(ms_allowin), 32'd1);
    chk("rstw_write_reg", 32'(ms_write_reg), 32'd0);
    cyc();
    resetn = 1'b1;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h5555_AAAA;
    #1;
    chk("stray_no_valid", 32'(ms_to_ws_valid), 32'd0);
    cyc();
    data_sram_data_ok = 1'b0;
    issue(mk(1'b1, 1'b1, 3'd0, 4'hF, 5'd12, 32'h3000_0004, 32'hBFC0_001C));
    chk("stray_not_kept", 32'(ms_to_ws_valid), 32'd0);
    data_sram_data_ok = 1'b1;
    cyc();
    data_sram_data_ok = 1'b0;

    // lwr at offset 1
    issue(mk(1'b1, 1'b1, 3'd6, 4'hF, 5'd13, 32'h4000_0001, 32'hBFC0_0020));
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hAABB_CCDD;
    #1;
`ifdef MEM_LWLR_EN
    chk("lwr_gr_we", 32'(ms_to_ws_bus[72:69]), 32'h7);
    chk("lwr_data", 32'(ms_to_ws_bus[55:32]), 32'hAABBCC);
`else
    chk("lwr_as_lw_gr_we", 32'(ms_to_ws_bus[72:69]), 32'hF);
    chk("lwr_as_lw_data", ms_to_ws_bus[63:32], 32'hAABB_CCDD);
`endif
    cyc();
    data_sram_data_ok = 1'b0;

    // sweep of load types/offsets, model-checked; offset 2 uses the buffer
    for (int t = 0; t < 7; t++) begin
      for (int o = 0; o < 4; o++) begin
        if ((t == 0 && o != 0) || ((t == 3 || t == 4) && o[0])) continue;
        issue(mk(1'b1, 1'b1, t[2:0], 4'hF, 5'(t + 1), 32'h5000_0000 + o, 32'(t * 16 + o)));
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = $urandom;
        if (o == 2) begin
          ws_allowin = 1'b0;
          cyc();
          data_sram_data_ok = 1'b0;
          data_sram_rdata   = $urandom;
          ws_allowin = 1'b1;
          cyc();
        end else begin
          cyc();
          data_sram_data_ok = 1'b0;
        end
      end
    end

    cyc(); cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
